// File: rtl/tl_buffer_2.sv
// rtl/tl_buffer_2.sv - TileLink A/D two-channel buffer; optional flow-through via TL_BUFFER_FLOW_EN
module tl_buffer_2_queue #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_bits
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          pass;
  logic          do_enq;
  logic          do_deq;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  // A full queue never accepts, even if it drains this cycle; this keeps
  // ready independent of the downstream ready.
  assign in_ready = !reset && !full;

`ifdef TL_BUFFER_FLOW_EN
  // An empty queue forwards the incoming beat straight to the output.
  assign pass      = empty && in_valid;
  assign out_valid = !reset && (!empty || in_valid);
  assign out_bits  = empty ? in_bits : mem[rd_ptr];
`else
  assign pass      = 1'b0;
  assign out_valid = !reset && !empty;
  assign out_bits  = mem[rd_ptr];
`endif

  // A forwarded beat that is taken immediately is neither stored nor popped.
  assign do_enq = in_valid && in_ready && !(pass && out_ready);
  assign do_deq = out_valid && out_ready && !pass;

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (do_enq) mem[wr_ptr] <= in_bits;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (do_deq) rd_ptr <= rd_ptr + AW'(1);
      if (do_enq && !do_deq)      count <= count + (AW+1)'(1);
      else if (!do_enq && do_deq) count <= count - (AW+1)'(1);
    end
  end
endmodule

module tl_buffer_2 #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [3:0]  auto_in_a_bits_size,
  input  logic [6:0]  auto_in_a_bits_source,
  input  logic [28:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  output logic        auto_out_a_valid,
  input  logic        auto_out_a_ready,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [3:0]  auto_out_a_bits_size,
  output logic [6:0]  auto_out_a_bits_source,
  output logic [28:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  input  logic        auto_out_d_valid,
  output logic        auto_out_d_ready,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_param,
  input  logic [3:0]  auto_out_d_bits_size,
  input  logic [6:0]  auto_out_d_bits_source,
  input  logic        auto_out_d_bits_sink,
  input  logic        auto_out_d_bits_denied,
  input  logic [63:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [3:0]  auto_in_d_bits_size,
  output logic [6:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);
  localparam int A_W = 119;
  localparam int D_W = 83;

  logic [A_W-1:0] a_in;
  logic [A_W-1:0] a_out;
  logic [D_W-1:0] d_in;
  logic [D_W-1:0] d_out;

  assign a_in = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                 auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                 auto_in_a_bits_data, auto_in_a_bits_corrupt};
  assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
          auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
          auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_out;

  assign d_in = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                 auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                 auto_out_d_bits_data, auto_out_d_bits_corrupt};
  assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
          auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
          auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_out;

  tl_buffer_2_queue #(.W(A_W), .DEPTH(DEPTH)) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (auto_in_a_valid),
    .in_ready  (auto_in_a_ready),
    .in_bits   (a_in),
    .out_valid (auto_out_a_valid),
    .out_ready (auto_out_a_ready),
    .out_bits  (a_out)
  );

  tl_buffer_2_queue #(.W(D_W), .DEPTH(DEPTH)) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (auto_out_d_valid),
    .in_ready  (auto_out_d_ready),
    .in_bits   (d_in),
    .out_valid (auto_in_d_valid),
    .out_ready (auto_in_d_ready),
    .out_bits  (d_out)
  );
endmodule

// File: doc/tl_buffer_2.md
TL_BUFFER_2 -- requirements
Module: tl_buffer_2

Interface
REQ-001 Parameter DEPTH, default 2: entries per channel queue; SHALL be a power of two and at least 2.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 auto_in_a_valid / auto_in_a_ready  input / output  1 / 1  upstream A-channel handshake.
REQ-005 auto_in_a_bits_{opcode,param,size,source,address,mask,data,corrupt}  input  3,3,4,7,29,8,64,1  upstream A payload.
REQ-006 auto_out_a_valid / auto_out_a_ready  output / input  1 / 1  downstream A-channel handshake.
REQ-007 auto_out_a_bits_*  output  same fields and widths as REQ-005  downstream A payload.
REQ-008 auto_out_d_valid / auto_out_d_ready  input / output  1 / 1  downstream D-channel handshake.
REQ-009 auto_out_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}  input  3,2,4,7,1,1,64,1  downstream D payload.
REQ-010 auto_in_d_valid / auto_in_d_ready  output / input  1 / 1  upstream D-channel handshake.
REQ-011 auto_in_d_bits_*  output  same fields and widths as REQ-009  upstream D payload.

Function
REQ-012 The block SHALL contain two independent DEPTH-entry FIFOs: A (auto_in_a to auto_out_a) and D (auto_out_d to auto_in_d); all payload fields of a beat SHALL be stored and emitted together, unmodified.
REQ-013 Each FIFO SHALL hold a write pointer and a read pointer of log2(DEPTH) bits, wrapping modulo DEPTH, and an occupancy count of log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-014 Enqueue SHALL occur when input valid and input ready are both high; dequeue SHALL occur when output valid and output ready are both high.
REQ-015 Input ready SHALL be high iff count < DEPTH; at full, ready SHALL be low even when the output dequeues in the same cycle.
REQ-016 Output valid SHALL be high iff count > 0 (except REQ-022); output payload SHALL be the entry at the read pointer.
REQ-017 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-018 Without REQ-022, latency SHALL be exactly one cycle: a beat enqueued in cycle N is first visible on the output in cycle N+1.
REQ-019 Output valid and payload SHALL be held stable while valid is high and ready is low.
REQ-020 Throughput SHALL be one beat per cycle per channel when neither side stalls and DEPTH is at least 2.

Reset
REQ-021 While reset is high, both FIFOs' pointers and counts SHALL clear to 0 at the clock edge, and all four valid/ready outputs SHALL be driven 0; storage contents SHALL NOT be reset, and beats in flight when reset asserts SHALL be discarded.

Configuration
REQ-022 Macro TL_BUFFER_FLOW_EN: when defined, an empty FIFO with input valid high SHALL drive output valid high and output payload equal to the input payload combinationally. When output ready is also high, the beat SHALL pass without being written and count SHALL stay 0; otherwise it SHALL be enqueued normally. When undefined, the behaviour SHALL be strictly REQ-016 and REQ-018.

Verification
REQ-023 After reset, drive one A beat (opcode 4, source 0x12, address 0x1000_0000) with auto_out_a_ready=1 -> auto_out_a_valid high exactly one cycle later, with identical fields; zero cycles later with TL_BUFFER_FLOW_EN.
REQ-024 Hold auto_out_a_ready=0 and offer 3 beats with DEPTH=2 -> 2 accepted, then auto_in_a_ready=0; release ready -> beats emitted in order 0,1,2 with no loss or duplication.
REQ-025 At full, assert output ready while input stays valid -> no enqueue that cycle; in the next cycle count=1 and ready=1, then the enqueue completes.
REQ-026 Stream 100 D beats with random valid and ready each at 50% -> output sequence equals input sequence, and no payload change while valid is high and ready is low.
REQ-027 Fill the D FIFO with 2 beats, then assert reset for one cycle -> auto_in_d_valid=0 and both ready outputs 0 during reset; after reset count=0 and no stale beat is emitted.
REQ-028 Run continuous traffic on A and D concurrently -> one beat per cycle per channel, with no interaction between the channels.
